// File: rtl/rex_pkg.sv
// Shared game definitions: FSM encoding and sprite geometry.
// The pixel decider imports the same constants so its bounding boxes
// always match the ones used for collision here.
package rex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2,
    ST_BAD  = 2'd3
  } game_st_t;

  // Geometry in pixels; y measured upward from the ground line.
  localparam logic signed [15:0] REX_LEFT  = 16'sd8;
  localparam logic signed [15:0] REX_W     = 16'sd24;
  localparam logic signed [15:0] REX_H     = 16'sd25;
  localparam logic signed [15:0] OBST_W    = 16'sd16;
  localparam logic signed [15:0] OBST_H    = 16'sd28;
  localparam logic signed [15:0] OBST_DOWN = 16'sd0;
  localparam logic signed [15:0] SCREEN_H  = 16'sd64;

  // Bounding-box overlap of rex and obstacle. Obstacle x is signed because
  // it goes negative while sliding off the left edge.
  function automatic logic rex_hit(input logic [15:0] obst_left,
                                   input logic [15:0] rex_bot);
    logic signed [15:0] ox;
    ox = $signed(obst_left);
    return (ox < (REX_LEFT + REX_W)) &&
           ((ox + OBST_W) > REX_LEFT) &&
           (rex_bot < $unsigned(OBST_H));
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a
// rising-edge detector; pulse is high for exactly one clk cycle per press.
module btn_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic btn_async,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // Synchroniser chain plus one extra stage holding the previous level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn_async;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/rex_game_ctrl.sv
// Game sequencer: IDLE/RUN/OVER state machine, rex jump physics,
// obstacle scroll, collision detection and score keeping. Outputs are
// registered and feed the pixel decider directly.
module rex_game_ctrl
  import rex_pkg::*;
#(
  parameter logic        [15:0] TICK_DIV   = 16'd50000,
  parameter logic signed [7:0]  JUMP_V0    = 8'sd8,
  parameter logic signed [7:0]  GRAVITY    = 8'sd1,
  parameter logic        [15:0] OBST_SPEED = 16'd2,
  parameter logic        [15:0] SCREEN_W   = 16'd128,
  parameter logic        [15:0] REX_CEIL   = 16'd39
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jump_btn,
  output logic [15:0] rex_down,
  output logic [15:0] obstacle_left,
  output logic [1:0]  game_state,
  output logic [15:0] score
);

  game_st_t           state_q, state_d;
  logic        [15:0] tick_cnt_q;
  logic               tick;
  logic               jmp;
  logic               hit;

  logic        [15:0] rex_down_q, rex_down_d;
  logic        [15:0] obst_q, obst_d;
  logic        [15:0] score_q, score_d;
  logic signed [7:0]  vel_q, vel_d;
  logic               airborne_q, airborne_d;

  logic        [15:0] obst_next;
  logic        [15:0] rex_next;

  btn_sync_edge u_jump_sync (
    .clk       (clk),
    .rstn      (rstn),
    .btn_async (jump_btn),
    .pulse     (jmp)
  );

  // Free-running game tick prescaler, active in every state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q <= 16'd0;
    end else if (tick) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  assign tick = (tick_cnt_q == (TICK_DIV - 16'd1));

  // Candidate positions for this tick, computed from registered state.
  assign obst_next = obst_q - OBST_SPEED;
  assign rex_next  = rex_down_q + {{8{vel_q[7]}}, vel_q};

  // Collision looks only at registered geometry, so it lags a tick by one cycle.
  assign hit = rex_hit(obst_q, rex_down_q);

  // State, physics and scroll registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rex_down_q <= 16'd0;
      obst_q     <= SCREEN_W;
      score_q    <= 16'd0;
      vel_q      <= 8'sd0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rex_down_q <= rex_down_d;
      obst_q     <= obst_d;
      score_q    <= score_d;
      vel_q      <= vel_d;
      airborne_q <= airborne_d;
    end
  end

  // Next-state and datapath update; a hit overrides any tick or launch.
  always_comb begin
    state_d    = state_q;
    rex_down_d = rex_down_q;
    obst_d     = obst_q;
    score_d    = score_q;
    vel_d      = vel_q;
    airborne_d = airborne_q;

    case (state_q)
      ST_IDLE: begin
        rex_down_d = 16'd0;
        obst_d     = SCREEN_W;
        score_d    = 16'd0;
        vel_d      = 8'sd0;
        airborne_d = 1'b0;
        if (jmp) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (hit) begin
          state_d = ST_OVER;
        end else begin
          if (tick) begin
            if ($signed(obst_next) <= -OBST_W) begin
              obst_d = SCREEN_W;
              if (score_q != 16'hFFFF) begin
                score_d = score_q + 16'd1;
              end
            end else begin
              obst_d = obst_next;
            end

            if (airborne_q) begin
              vel_d = vel_q - GRAVITY;
              if ($signed(rex_next) <= 16'sd0) begin
                rex_down_d = 16'd0;
                vel_d      = 8'sd0;
                airborne_d = 1'b0;
              end else if ($signed(rex_next) > $signed(REX_CEIL)) begin
                rex_down_d = REX_CEIL;
              end else begin
                rex_down_d = rex_next;
              end
            end
          end

          // Launch uses the pre-launch airborne flag, so a coincident tick
          // leaves rex_down unchanged this cycle.
          if (jmp && !airborne_q) begin
            vel_d      = JUMP_V0;
            airborne_d = 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (jmp) begin
          state_d    = ST_IDLE;
          rex_down_d = 16'd0;
          obst_d     = SCREEN_W;
          score_d    = 16'd0;
          vel_d      = 8'sd0;
          airborne_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rex_down      = rex_down_q;
  assign obstacle_left = obst_q;
  assign score         = score_q;
  assign game_state    = state_q;

endmodule

// File: tb/tb_rex_game_ctrl.sv
// Directed bench for rex_game_ctrl with a 4-cycle game tick.
module tb_rex_game_ctrl;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b1;
  logic        jump_btn = 1'b0;
  logic [15:0] rex_down;
  logic [15:0] obstacle_left;
  logic [1:0]  game_state;
  logic [15:0] score;

  int tests = 0;
  int fails = 0;
  int tb_cnt;

  // Expected rex heights per tick after a launch.
  logic [15:0] arc_exp [17] = '{16'd8, 16'd15, 16'd21, 16'd26, 16'd30, 16'd33,
                                16'd35, 16'd36, 16'd36, 16'd35, 16'd33, 16'd30,
                                16'd26, 16'd21, 16'd15, 16'd8, 16'd0};

  rex_game_ctrl #(
    .TICK_DIV (16'd4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .jump_btn      (jump_btn),
    .rex_down      (rex_down),
    .obstacle_left (obstacle_left),
    .game_state    (game_state),
    .score         (score)
  );

  // Clock and tick-phase model: tb_cnt is the prescaler count that decides
  // whether the upcoming rising edge is a game tick (tb_cnt == 3).
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge where tb_cnt == c.
  task automatic wait_cnt(input int c);
    int n = 0;
    while (tb_cnt != c && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (tb_cnt != c) check("align_timeout", 16'(tb_cnt), 16'(c));
  endtask

  // Advance through exactly one tick edge, ending at the following negedge.
  task automatic step_tick();
    wait_cnt(3);
    @(negedge clk);
  endtask

  // Raise the button so its pulse acts on the 3rd rising edge; returns at
  // the negedge right after that edge.
  task automatic press_at(input int c);
    wait_cnt(c);
    jump_btn = 1'b1;
    repeat (3) @(negedge clk);
    jump_btn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_state", 16'(game_state), 16'd0);
    check("rst_rex", rex_down, 16'd0);
    check("rst_obst", obstacle_left, 16'd128);
    check("rst_score", score, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_idle", 16'(game_state), 16'd0);
  endtask

  // Start the game from IDLE; ends at a negedge where the next edge is a tick.
  task automatic start_game();
    press_at(0);
    check("start_state", 16'(game_state), 16'd1);
    check("start_obst", obstacle_left, 16'd128);
  endtask

  initial begin
    // Reset asserted before any clock edge.
    #1 rstn = 1'b0;
    #1;
    check("por_state", 16'(game_state), 16'd0);
    check("por_rex", rex_down, 16'd0);
    check("por_obst", obstacle_left, 16'd128);
    check("por_score", score, 16'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Start: RUN appears on the 3rd rising edge after the button rises.
    wait_cnt(0);
    jump_btn = 1'b1;
    repeat (2) @(negedge clk);
    check("start_edge2_idle", 16'(game_state), 16'd0);
    @(negedge clk);
    jump_btn = 1'b0;
    check("start_edge3_run", 16'(game_state), 16'd1);
    check("start_rex", rex_down, 16'd0);

    // Jump arc, with a mid-air second press that must be ignored.
    press_at(0);
    check("launch_rex", rex_down, 16'd0);
    for (int i = 0; i < 17; i++) begin
      if (i == 5) press_at(0);
      step_tick();
      check($sformatf("arc_%0d", i), rex_down, arc_exp[i]);
    end
    check("arc_landed", 16'(dut.airborne_q), 16'd0);
    step_tick();
    check("arc_ground", rex_down, 16'd0);

    // Launch coinciding with a tick.
    do_reset();
    start_game();
    press_at(1);
    check("sim_launch_rex", rex_down, 16'd0);
    check("sim_launch_obst", obstacle_left, 16'd124);
    step_tick();
    check("sim_next_rex", rex_down, 16'd8);
    check("sim_next_obst", obstacle_left, 16'd122);
    step_tick();
    check("sim_next2_rex", rex_down, 16'd15);

    // Reset while airborne in RUN.
    do_reset();

    // Obstacle wrap and scoring with the rex held above the obstacle.
    start_game();
    force dut.rex_down_q = 16'd39;
    for (int k = 1; k <= 71; k++) begin
      step_tick();
      check($sformatf("scroll_%0d", k), obstacle_left, 16'(128 - 2 * k));
    end
    check("pre_wrap_score", score, 16'd0);
    step_tick();
    check("wrap_obst", obstacle_left, 16'd128);
    check("wrap_score", score, 16'd1);
    force dut.score_q = 16'hFFFF;
    @(negedge clk);
    release dut.score_q;
    check("forced_score", score, 16'hFFFF);
    repeat (72) step_tick();
    check("sat_obst", obstacle_left, 16'd128);
    check("sat_score", score, 16'hFFFF);
    release dut.rex_down_q;
    do_reset();

    // Collision with a grounded rex.
    start_game();
    repeat (48) step_tick();
    check("col_pre_obst", obstacle_left, 16'd32);
    check("col_pre_state", 16'(game_state), 16'd1);
    step_tick();
    check("col_hit_obst", obstacle_left, 16'd30);
    check("col_hit_state", 16'(game_state), 16'd1);
    @(negedge clk);
    check("col_over_state", 16'(game_state), 16'd2);
    repeat (20) step_tick();
    check("over_obst", obstacle_left, 16'd30);
    check("over_score", score, 16'd0);
    check("over_state", 16'(game_state), 16'd2);
    press_at(0);
    check("restart_state", 16'(game_state), 16'd0);
    check("restart_obst", obstacle_left, 16'd128);
    check("restart_rex", rex_down, 16'd0);
    do_reset();

    // Hit coinciding with a tick: the tick update is discarded.
    start_game();
    force dut.rex_down_q = 16'd39;
    repeat (54) step_tick();
    check("simhit_pre_obst", obstacle_left, 16'd20);
    wait_cnt(3);
    force dut.rex_down_q = 16'd0;
    @(negedge clk);
    release dut.rex_down_q;
    check("simhit_state", 16'(game_state), 16'd2);
    check("simhit_obst", obstacle_left, 16'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
